cd_io_bridge: RTL and testbench

CD_IO_BRIDGE -- requirements
Module: cd_io_bridge

---
 rtl/cd_io_pkg.sv | 40 ++++
 rtl/cd_io_fifo.sv | 45 ++++
 rtl/cd_io_bridge.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_cd_io_bridge.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_io_pkg.sv
// Shared opcodes, status-bit positions and transaction phase enum
// for the CD IO bridge.
package cd_io_pkg;

   localparam logic [7:0] OPC_STAT_GET  = 8'h60;
   localparam logic [7:0] OPC_STAT_SEND = 8'h61;
   localparam logic [7:0] OPC_CMD_GET   = 8'h62;
   localparam logic [7:0] OPC_STREAM    = 8'h64;

   localparam int SB_OVF  = 7;
   localparam int SB_CRST = 6;
   localparam int SB_SPD  = 4;
   localparam int SB_PEND = 3;

   localparam int PIDX_W = 8;

   typedef enum logic [2:0] {
      OP_OPCODE,
      OP_STAT_GET,
      OP_STAT_SEND,
      OP_CMD_GET,
      OP_STREAM,
      OP_IGNORE
   } op_e;

   function automatic op_e op_decode(input logic [7:0] b, input int ns);
      op_e r;
      r = OP_IGNORE;
      if (b == OPC_STAT_GET)
         r = OP_STAT_GET;
      else if (b == OPC_STAT_SEND)
         r = OP_STAT_SEND;
      else if (b == OPC_CMD_GET)
         r = OP_CMD_GET;
      else if (b >= OPC_STREAM && int'(b) < int'(OPC_STREAM) + ns)
         r = OP_STREAM;
      return r;
   endfunction

endpackage

// File: rtl/cd_io_fifo.sv
// Small synchronous word FIFO with full/empty flags.
// Pushes into a full FIFO are discarded.
module cd_io_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/cd_io_bridge.sv
// SPI-to-CD bridge: status/command exchange and stream write FIFOs.
// Optional sticky per-stream overflow flags with CD_IO_OVF_EN.
module cd_io_bridge
   import cd_io_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 11,
   parameter int STAT_BYTES = 5,
   parameter int CMD_BYTES  = 5,
   parameter int NSTREAM    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic                    SPI_SCK,
   input  logic                    SPI_SS2,
   input  logic                    SPI_DI,
   output logic                    SPI_DO,
   input  logic [1:0]              CD_SPEED,
   input  logic                    CORE_RESET,
   output logic                    CD_DATA_DOWNLOAD,
   output logic [NSTREAM-1:0]      STREAM_WR,
   input  logic [NSTREAM-1:0]      STREAM_READY,
   output logic [DATA_W-1:0]       STREAM_DIN,
   output logic [ADDR_W-1:0]       STREAM_ADDR,
   output logic [8*STAT_BYTES-1:0] CDD_STATUS_IN,
   output logic                    CDD_STATUS_LATCH,
   input  logic [8*CMD_BYTES-1:0]  CDD_COMMAND_DATA,
   input  logic                    CDD_COMMAND_SEND
`ifdef CD_IO_OVF_EN
   ,
   output logic [NSTREAM-1:0]      OVERFLOW
`endif
);

   localparam int BPW = DATA_W / 8;
   localparam int FW  = DATA_W + ADDR_W;
   localparam int WB  = (DATA_W > 8) ? DATA_W - 8 : 1;

   logic [2:0] sck_r;
   logic [1:0] ss_r;
   logic [1:0] di_r;
   logic       ss;
   logic       rise;
   logic       fall;

   op_e op_q;
   op_e op_d;

   logic [2:0]        bit_cnt;
   logic [6:0]        shreg;
   logic [PIDX_W-1:0] pidx;
   logic [1:0]        wcnt;
   logic [WB-1:0]     wbuf;
   logic [ADDR_W-1:0] widx;
   logic [1:0]        sel;
   logic              do_r;

   logic [8*CMD_BYTES-1:0] snap;
   logic                   pending;

   logic              byte_done;
   logic [7:0]        byte_val;
   logic [WB+7:0]     cat;
   logic [DATA_W-1:0] word_val;
   logic              word_end;
   logic              word_done;
   logic              wr_stat;
   logic              clr_ovf;
   logic              ovf_any;

   logic [7:0] stat_byte;
   logic [7:0] cmd_byte;
   logic [7:0] tx_byte;
   logic [2:0] space;

   logic [NSTREAM-1:0] push;
   logic [NSTREAM-1:0] pop;
   logic [NSTREAM-1:0] full;
   logic [NSTREAM-1:0] empty;
   logic [FW-1:0]      fdout [NSTREAM];

   assign ss   = ss_r[1];
   assign rise = !ss && sck_r[1] && !sck_r[2];
   assign fall = !ss && !sck_r[1] && sck_r[2];

   assign byte_done = rise && (bit_cnt == 3'd7);
   assign byte_val  = {shreg, di_r[1]};
   assign cat       = {wbuf, byte_val};
   assign word_val  = cat[DATA_W-1:0];
   assign word_end  = (wcnt == 2'(BPW - 1));
   assign word_done = byte_done && (op_q == OP_STREAM) && word_end;
   assign wr_stat   = byte_done && (op_q == OP_STAT_SEND);
   assign clr_ovf   = byte_done && (op_q == OP_OPCODE) &&
                      (byte_val == OPC_STAT_GET);

   // Sync flops reset low so a reset inside a live transaction
   // keeps ignoring bytes until SS2 is seen high again.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sck_r <= '0;
         ss_r  <= '0;
         di_r  <= '0;
      end else begin
         sck_r <= {sck_r[1:0], SPI_SCK};
         ss_r  <= {ss_r[0], SPI_SS2};
         di_r  <= {di_r[0], SPI_DI};
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         op_q <= OP_IGNORE;
      else
         op_q <= op_d;
   end

   always_comb begin
      op_d = op_q;
      if (ss)
         op_d = OP_OPCODE;
      else if (byte_done && op_q == OP_OPCODE)
         op_d = op_decode(byte_val, NSTREAM);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         shreg   <= '0;
         pidx    <= '0;
         wcnt    <= '0;
         wbuf    <= '0;
         widx    <= '0;
         sel     <= '0;
      end else if (ss) begin
         bit_cnt <= '0;
         pidx    <= '0;
         wcnt    <= '0;
         widx    <= '0;
      end else if (rise) begin
         bit_cnt <= bit_cnt + 3'd1;
         shreg   <= {shreg[5:0], di_r[1]};
         if (bit_cnt == 3'd7) begin
            if (op_q == OP_OPCODE)
               sel <= byte_val[1:0];
            else if (pidx != '1)
               pidx <= pidx + 1'b1;
            if (op_q == OP_STREAM) begin
               wbuf <= cat[WB-1:0];
               wcnt <= word_end ? 2'd0 : wcnt + 2'd1;
               if (word_end)
                  widx <= widx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         CDD_STATUS_IN    <= '0;
         CDD_STATUS_LATCH <= 1'b0;
      end else begin
         CDD_STATUS_LATCH <= wr_stat &&
                             (pidx == PIDX_W'(STAT_BYTES - 1));
         for (int k = 0; k < STAT_BYTES; k++)
            if (wr_stat && pidx == PIDX_W'(k))
               CDD_STATUS_IN[8*k +: 8] <= byte_val;
      end
   end

   // A new command arriving with the first CMD_GET byte keeps pending set.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         snap    <= '0;
         pending <= 1'b0;
      end else if (CDD_COMMAND_SEND) begin
         snap    <= CDD_COMMAND_DATA;
         pending <= 1'b1;
      end else if (byte_done && op_q == OP_CMD_GET && pidx == '0) begin
         pending <= 1'b0;
      end
   end

   always_comb begin
      space = '0;
      for (int s = 0; s < NSTREAM; s++)
         space[s] = !full[s];
   end

   always_comb begin
      stat_byte = '0;
      stat_byte[SB_OVF]             = ovf_any;
      stat_byte[SB_CRST]            = CORE_RESET;
      stat_byte[SB_SPD +: 2]        = CD_SPEED;
      stat_byte[SB_PEND]            = pending;
      stat_byte[2:0]                = space;
   end

   always_comb begin
      cmd_byte = '0;
      for (int k = 0; k < CMD_BYTES; k++)
         if (pidx == PIDX_W'(k))
            cmd_byte = snap[8*k +: 8];
   end

   assign tx_byte = (op_q == OP_CMD_GET) ? cmd_byte : stat_byte;

   // MSB of the first byte is preloaded while SS2 is idle.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         do_r <= 1'b0;
      else if (ss)
         do_r <= stat_byte[7];
      else if (fall)
         do_r <= tx_byte[3'd7 - bit_cnt];
   end

   assign SPI_DO = (SPI_SS2 || reset) ? 1'bz : do_r;

   always_comb begin
      push = '0;
      for (int s = 0; s < NSTREAM; s++)
         push[s] = word_done && (sel == 2'(s));
   end

   for (genvar s = 0; s < NSTREAM; s++) begin : g_fifo
      cd_io_fifo #(
         .W     (FW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk_sys),
         .reset (reset),
         .push  (push[s]),
         .din   ({word_val, widx}),
         .pop   (pop[s]),
         .dout  (fdout[s]),
         .full  (full[s]),
         .empty (empty[s])
      );
   end

   always_comb begin
      pop = '0;
      for (int s = NSTREAM - 1; s >= 0; s--)
         if (!empty[s] && STREAM_READY[s]) begin
            pop    = '0;
            pop[s] = 1'b1;
         end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         STREAM_WR   <= '0;
         STREAM_DIN  <= '0;
         STREAM_ADDR <= '0;
      end else begin
         STREAM_WR <= pop;
         for (int s = 0; s < NSTREAM; s++)
            if (pop[s])
               {STREAM_DIN, STREAM_ADDR} <= fdout[s];
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         CD_DATA_DOWNLOAD <= 1'b0;
      else if (byte_done && op_q == OP_STREAM && sel == 2'd0)
         CD_DATA_DOWNLOAD <= 1'b1;
      else if (ss && empty[0])
         CD_DATA_DOWNLOAD <= 1'b0;
   end

`ifdef CD_IO_OVF_EN
   logic [NSTREAM-1:0] ovf_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         ovf_q <= '0;
      else
         ovf_q <= (clr_ovf ? '0 : ovf_q) | (push & full);
   end

   assign OVERFLOW = ovf_q;
   assign ovf_any  = |ovf_q;
`else
   assign ovf_any = 1'b0;
`endif

endmodule

// File: tb/tb_cd_io_bridge.sv
// Directed self-checking bench for cd_io_bridge.
// Optional overflow checks follow CD_IO_OVF_EN.
module tb_cd_io_bridge;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 11;
   localparam int NS     = 2;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   logic SPI_SCK = 1'b0;
   logic SPI_SS2 = 1'b1;
   logic SPI_DI  = 1'b0;
   tri1  spi_do;
   logic [1:0]        CD_SPEED = 2'b10;
   logic              CORE_RESET = 1'b0;
   logic              CD_DATA_DOWNLOAD;
   logic [NS-1:0]     STREAM_WR;
   logic [NS-1:0]     STREAM_READY = '1;
   logic [DATA_W-1:0] STREAM_DIN;
   logic [ADDR_W-1:0] STREAM_ADDR;
   logic [39:0]       CDD_STATUS_IN;
   logic              CDD_STATUS_LATCH;
   logic [39:0]       CDD_COMMAND_DATA = '0;
   logic              CDD_COMMAND_SEND = 1'b0;
`ifdef CD_IO_OVF_EN
   logic [NS-1:0]     OVERFLOW;
`endif

   int tests = 0;
   int fails = 0;
   int latch_cnt = 0;
   time last_rise = 0;

   int          q_str  [$];
   logic [15:0] q_data [$];
   logic [10:0] q_addr [$];
   time         q_time [$];

   always #5 clk_sys = ~clk_sys;

   cd_io_bridge #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAT_BYTES(5),
      .CMD_BYTES(5), .NSTREAM(NS), .FIFO_DEPTH(4)
   ) dut (
      .clk_sys          (clk_sys),
      .reset            (reset),
      .SPI_SCK          (SPI_SCK),
      .SPI_SS2          (SPI_SS2),
      .SPI_DI           (SPI_DI),
      .SPI_DO           (spi_do),
      .CD_SPEED         (CD_SPEED),
      .CORE_RESET       (CORE_RESET),
      .CD_DATA_DOWNLOAD (CD_DATA_DOWNLOAD),
      .STREAM_WR        (STREAM_WR),
      .STREAM_READY     (STREAM_READY),
      .STREAM_DIN       (STREAM_DIN),
      .STREAM_ADDR      (STREAM_ADDR),
      .CDD_STATUS_IN    (CDD_STATUS_IN),
      .CDD_STATUS_LATCH (CDD_STATUS_LATCH),
      .CDD_COMMAND_DATA (CDD_COMMAND_DATA),
      .CDD_COMMAND_SEND (CDD_COMMAND_SEND)
`ifdef CD_IO_OVF_EN
      ,
      .OVERFLOW         (OVERFLOW)
`endif
   );

   always @(negedge clk_sys) begin
      if (CDD_STATUS_LATCH)
         latch_cnt++;
      for (int s = 0; s < NS; s++)
         if (STREAM_WR[s]) begin
            q_str.push_back(s);
            q_data.push_back(STREAM_DIN);
            q_addr.push_back(STREAM_ADDR);
            q_time.push_back($time);
         end
   end

   task automatic clr_q();
      q_str.delete();
      q_data.delete();
      q_addr.delete();
      q_time.delete();
   endtask

   task automatic spi_begin();
      @(negedge clk_sys);
      SPI_SS2 = 1'b0;
      #40;
   endtask

   task automatic spi_end();
      #40;
      SPI_SS2 = 1'b1;
      #200;
   endtask

   task automatic spi_xfer(input logic [7:0] tx, input int n,
                           output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - n; i--) begin
         SPI_DI = tx[i];
         #40;
         rx[i] = spi_do;
         SPI_SCK = 1'b1;
         last_rise = $time;
         #40;
         SPI_SCK = 1'b0;
      end
   endtask

   task automatic stat_get(output logic [7:0] rx);
      spi_begin();
      spi_xfer(8'h60, 8, rx);
      spi_end();
   endtask

   task automatic test_reset();
      logic [7:0] rx;
      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      tests++;
      if (spi_do !== 1'b1) begin
         fails++;
         $display("FAIL reset_do_z: got %b required released (pulled 1)", spi_do);
      end
      tests++;
      if (STREAM_WR !== '0 || CD_DATA_DOWNLOAD !== 1'b0 ||
          CDD_STATUS_LATCH !== 1'b0) begin
         fails++;
         $display("FAIL reset_outs: wr=%b dl=%b latch=%b required 0",
                  STREAM_WR, CD_DATA_DOWNLOAD, CDD_STATUS_LATCH);
      end
      tests++;
      if (CDD_STATUS_IN !== 40'h0) begin
         fails++;
         $display("FAIL reset_status_in: got %h required 0", CDD_STATUS_IN);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk_sys);
      stat_get(rx);
      tests++;
      if (rx !== 8'h23) begin
         fails++;
         $display("FAIL reset_status_byte: got %h required 23", rx);
      end
   endtask

   task automatic test_stat_send();
      logic [7:0] rx;
      logic [7:0] rx0;
      latch_cnt = 0;
      spi_begin();
      spi_xfer(8'h61, 8, rx0);
      for (int k = 1; k <= 6; k++)
         spi_xfer(8'(k), 8, rx);
      spi_end();
      tests++;
      if (rx0 !== 8'h23 || rx !== 8'h23) begin
         fails++;
         $display("FAIL stat_send_do: got %h/%h required 23/23", rx0, rx);
      end
      tests++;
      if (CDD_STATUS_IN !== 40'h0504030201) begin
         fails++;
         $display("FAIL stat_send_data: got %h required 0504030201",
                  CDD_STATUS_IN);
      end
      tests++;
      if (latch_cnt != 1) begin
         fails++;
         $display("FAIL stat_send_latch: got %0d pulses required 1", latch_cnt);
      end
   endtask

   task automatic test_cmd_get();
      logic [7:0] rx;
      logic [7:0] exp [6];
      exp = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h00};
      CDD_COMMAND_DATA = 40'hAABBCCDDEE;
      @(negedge clk_sys);
      CDD_COMMAND_SEND = 1'b1;
      @(negedge clk_sys);
      CDD_COMMAND_SEND = 1'b0;
      CDD_COMMAND_DATA = 40'h0;
      repeat (2) @(negedge clk_sys);
      stat_get(rx);
      tests++;
      if (rx !== 8'h2B) begin
         fails++;
         $display("FAIL cmd_pending_set: got %h required 2b", rx);
      end
      spi_begin();
      spi_xfer(8'h62, 8, rx);
      tests++;
      if (rx !== 8'h2B) begin
         fails++;
         $display("FAIL cmd_get_opcode_do: got %h required 2b", rx);
      end
      for (int k = 0; k < 6; k++) begin
         spi_xfer(8'h00, 8, rx);
         tests++;
         if (rx !== exp[k]) begin
            fails++;
            $display("FAIL cmd_get_byte%0d: got %h required %h", k, rx, exp[k]);
         end
      end
      spi_end();
      stat_get(rx);
      tests++;
      if (rx !== 8'h23) begin
         fails++;
         $display("FAIL cmd_pending_clr: got %h required 23", rx);
      end
   endtask

   task automatic test_stream();
      logic [7:0] rx;
      time t0;
      clr_q();
      STREAM_READY = '1;
      spi_begin();
      spi_xfer(8'h64, 8, rx);
      spi_xfer(8'h12, 8, rx);
      spi_xfer(8'h34, 8, rx);
      t0 = last_rise;
      spi_xfer(8'h56, 8, rx);
      spi_xfer(8'h78, 8, rx);
      #80;
      tests++;
      if (CD_DATA_DOWNLOAD !== 1'b1) begin
         fails++;
         $display("FAIL stream_dl_active: got %b required 1", CD_DATA_DOWNLOAD);
      end
      spi_end();
      tests++;
      if (CD_DATA_DOWNLOAD !== 1'b0) begin
         fails++;
         $display("FAIL stream_dl_end: got %b required 0", CD_DATA_DOWNLOAD);
      end
      tests++;
      if (q_data.size() != 2) begin
         fails++;
         $display("FAIL stream_wr_count: got %0d required 2", q_data.size());
      end else begin
         tests++;
         if (q_str[0] != 0 || q_data[0] !== 16'h1234 || q_addr[0] !== 11'd0) begin
            fails++;
            $display("FAIL stream_word0: got s%0d %h @%0d required s0 1234 @0",
                     q_str[0], q_data[0], q_addr[0]);
         end
         tests++;
         if (q_str[1] != 0 || q_data[1] !== 16'h5678 || q_addr[1] !== 11'd1) begin
            fails++;
            $display("FAIL stream_word1: got s%0d %h @%0d required s0 5678 @1",
                     q_str[1], q_data[1], q_addr[1]);
         end
         tests++;
         if (q_time[0] - t0 != 40) begin
            fails++;
            $display("FAIL stream_latency: got %0t required 40 after rise",
                     q_time[0] - t0);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] rx;
      logic [7:0] exp_st;
      clr_q();
      STREAM_READY = 2'b01;
      spi_begin();
      spi_xfer(8'h65, 8, rx);
      for (int w = 1; w <= 6; w++) begin
         spi_xfer(8'h00, 8, rx);
         spi_xfer(8'(w), 8, rx);
      end
      spi_end();
      tests++;
      if (q_data.size() != 0 || CD_DATA_DOWNLOAD !== 1'b0) begin
         fails++;
         $display("FAIL ovf_hold: got %0d writes dl=%b required 0/0",
                  q_data.size(), CD_DATA_DOWNLOAD);
      end
`ifdef CD_IO_OVF_EN
      exp_st = 8'hA1;
      tests++;
      if (OVERFLOW !== 2'b10) begin
         fails++;
         $display("FAIL ovf_flag: got %b required 10", OVERFLOW);
      end
`else
      exp_st = 8'h21;
`endif
      stat_get(rx);
      tests++;
      if (rx !== exp_st) begin
         fails++;
         $display("FAIL ovf_status: got %h required %h", rx, exp_st);
      end
      stat_get(rx);
      tests++;
      if (rx !== 8'h21) begin
         fails++;
         $display("FAIL ovf_cleared_status: got %h required 21", rx);
      end
`ifdef CD_IO_OVF_EN
      tests++;
      if (OVERFLOW !== 2'b00) begin
         fails++;
         $display("FAIL ovf_flag_clr: got %b required 00", OVERFLOW);
      end
`endif
      STREAM_READY = 2'b11;
      repeat (10) @(negedge clk_sys);
      tests++;
      if (q_data.size() != 4) begin
         fails++;
         $display("FAIL ovf_kept: got %0d words required 4", q_data.size());
      end else begin
         for (int w = 0; w < 4; w++) begin
            tests++;
            if (q_str[w] != 1 || q_data[w] !== 16'(w + 1) ||
                q_addr[w] !== 11'(w)) begin
               fails++;
               $display("FAIL ovf_word%0d: got s%0d %h @%0d required s1 %h @%0d",
                        w, q_str[w], q_data[w], q_addr[w], w + 1, w);
            end
         end
      end
      stat_get(rx);
      tests++;
      if (rx !== 8'h23) begin
         fails++;
         $display("FAIL ovf_drained_status: got %h required 23", rx);
      end
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      clr_q();
      latch_cnt = 0;
      spi_begin();
      spi_xfer(8'h64, 8, rx);
      spi_xfer(8'h12, 8, rx);
      spi_xfer(8'h34, 8, rx);
      spi_xfer(8'h56, 8, rx);
      spi_end();
      tests++;
      if (q_data.size() != 1 || q_data[0] !== 16'h1234 || q_addr[0] !== 11'd0) begin
         fails++;
         $display("FAIL abort_word: got %0d words first %h required 1 word 1234",
                  q_data.size(), (q_data.size() > 0) ? q_data[0] : 16'hxxxx);
      end
      spi_begin();
      spi_xfer(8'h61, 8, rx);
      spi_xfer(8'hAA, 8, rx);
      spi_xfer(8'hBB, 8, rx);
      spi_xfer(8'hCC, 4, rx);
      spi_end();
      tests++;
      if (CDD_STATUS_IN !== 40'h050403BBAA || latch_cnt != 0) begin
         fails++;
         $display("FAIL abort_stat_send: got %h latch %0d required 050403bbaa latch 0",
                  CDD_STATUS_IN, latch_cnt);
      end
      clr_q();
      spi_begin();
      spi_xfer(8'h64, 8, rx);
      spi_xfer(8'hAB, 8, rx);
      spi_xfer(8'hCD, 8, rx);
      spi_end();
      tests++;
      if (q_data.size() != 1 || q_data[0] !== 16'hABCD || q_addr[0] !== 11'd0) begin
         fails++;
         $display("FAIL abort_next_opcode: got %0d words first %h required 1 word abcd @0",
                  q_data.size(), (q_data.size() > 0) ? q_data[0] : 16'hxxxx);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx;
      clr_q();
      STREAM_READY = 2'b00;
      spi_begin();
      spi_xfer(8'h64, 8, rx);
      spi_xfer(8'h12, 8, rx);
      spi_xfer(8'h34, 8, rx);
      spi_xfer(8'h56, 4, rx);
      @(negedge clk_sys);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      tests++;
      if (spi_do !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_do_z: got %b required released (pulled 1)", spi_do);
      end
      tests++;
      if (STREAM_WR !== '0 || CD_DATA_DOWNLOAD !== 1'b0 ||
          CDD_STATUS_IN !== 40'h0 || CDD_STATUS_LATCH !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_outs: wr=%b dl=%b st=%h latch=%b required 0",
                  STREAM_WR, CD_DATA_DOWNLOAD, CDD_STATUS_IN, CDD_STATUS_LATCH);
      end
      reset = 1'b0;
      STREAM_READY = 2'b11;
      repeat (10) @(negedge clk_sys);
      tests++;
      if (q_data.size() != 0) begin
         fails++;
         $display("FAIL rst_mid_fifo_empty: got %0d writes required 0", q_data.size());
      end
      spi_xfer(8'h64, 8, rx);
      spi_xfer(8'h99, 8, rx);
      spi_xfer(8'h88, 8, rx);
      spi_end();
      tests++;
      if (q_data.size() != 0 || CD_DATA_DOWNLOAD !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_ignored: got %0d writes dl=%b required 0/0",
                  q_data.size(), CD_DATA_DOWNLOAD);
      end
      spi_begin();
      spi_xfer(8'h64, 8, rx);
      spi_xfer(8'h55, 8, rx);
      spi_xfer(8'h66, 8, rx);
      spi_end();
      tests++;
      if (q_data.size() != 1 || q_data[0] !== 16'h5566 || q_addr[0] !== 11'd0) begin
         fails++;
         $display("FAIL rst_mid_recover: got %0d words first %h required 1 word 5566 @0",
                  q_data.size(), (q_data.size() > 0) ? q_data[0] : 16'hxxxx);
      end
   endtask

   initial begin
      test_reset();
      test_stat_send();
      test_cmd_get();
      test_stream();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
